// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc+inst buffer that parks a fetch response while decode is stalled.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clr,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      inst  <= NOP_INST;
    end else if (clr || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      inst  <= inst_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request outstanding to
// instruction memory and presents one instruction per cycle to the IF/ID register.
//
// state   | meaning
// FETCH   | request outstanding at req_addr; response goes to the output slot or skid
// HOLD    | response parked in the skid while decode stalls; no request issued
// DISCARD | stale request left over from a redirect; wait for its ack, drop the data
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_cur,
  output logic [31:0] inst,
  output logic [31:0] pc_add4,
  output logic        if_valid
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        xfer, slot_free;
  logic        slot_ld, slot_clr, slot_from_skid;
  logic        skid_ld, skid_unload, skid_clr, skid_valid;
  logic [31:0] skid_pc, skid_inst;
  logic [31:0] slot_pc, slot_inst;

  // Request decodes from state only, so memory never sees a path from im_ack.
  assign im_req    = !rst && (state != HOLD);
  assign im_addr   = req_addr;
  assign xfer      = im_req && im_ack;
  assign slot_free = !if_valid || !stall;
  assign slot_pc   = slot_from_skid ? skid_pc   : req_addr;
  assign slot_inst = slot_from_skid ? skid_inst : im_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_addr_nxt   = req_addr;
    slot_ld        = 1'b0;
    slot_clr       = 1'b0;
    slot_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_unload    = 1'b0;
    skid_clr       = 1'b0;

    if (redirect) begin
      slot_clr = 1'b1;
      skid_clr = 1'b1;
      pc_nxt   = redirect_pc;
      // An unacked request must keep its address; the target waits in pc.
      if (im_req && !im_ack) begin
        state_nxt = DISCARD;
      end else begin
        state_nxt    = FETCH;
        req_addr_nxt = redirect_pc;
      end
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            pc_nxt       = pc_plus4(req_addr);
            req_addr_nxt = pc_plus4(req_addr);
            if (slot_free) begin
              slot_ld = 1'b1;
            end else begin
              skid_ld   = 1'b1;
              state_nxt = HOLD;
            end
          end else if (!stall) begin
            slot_clr = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            slot_from_skid = 1'b1;
            slot_ld        = skid_valid;
            slot_clr       = !skid_valid;
            skid_unload    = 1'b1;
            state_nxt      = FETCH;
          end
        end
        DISCARD: begin
          if (xfer) begin
            req_addr_nxt = pc;
            state_nxt    = FETCH;
          end
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      inst     <= NOP_INST;
      pc_cur   <= 32'h0000_0000;
      pc_add4  <= 32'h0000_0004;
    end else if (slot_clr) begin
      if_valid <= 1'b0;
      inst     <= NOP_INST;
    end else if (slot_ld) begin
      if_valid <= 1'b1;
      inst     <= slot_inst;
      pc_cur   <= slot_pc;
      pc_add4  <= pc_plus4(slot_pc);
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_ld),
    .unload  (skid_unload),
    .clr     (skid_clr),
    .pc_in   (req_addr),
    .inst_in (im_rdata),
    .valid   (skid_valid),
    .pc      (skid_pc),
    .inst    (skid_inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage and a variable-latency memory.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic [31:0] pc_cur, inst, pc_add4;
  logic        if_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata), .pc_cur(pc_cur), .inst(inst),
    .pc_add4(pc_add4), .if_valid(if_valid)
  );

  // Model: address being fetched, pending redirect target while a stale
  // request drains, parked responses, and the presented instruction.
  logic [31:0] m_addr, m_next_pc, m_pc, m_inst;
  logic        m_drop, m_valid;
  logic [31:0] m_buf_pc[$];
  logic [31:0] m_buf_inst[$];

  int lat_fixed = 0;
  int lat_target = 0;
  int lat_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  function automatic logic m_req();
    return !rst && (m_buf_pc.size() == 0);
  endfunction

  function automatic int pick_lat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr    = TB_RESET_PC;
    m_next_pc = TB_RESET_PC;
    m_drop    = 1'b0;
    m_valid   = 1'b0;
    m_pc      = 32'h0;
    m_inst    = NOP_INST;
    m_buf_pc.delete();
    m_buf_inst.delete();
  endtask

  // Compare point: mid-cycle, after the previous edge has settled.
  task automatic sample();
    @(negedge clk);
    chk("im_req", 32'(im_req), 32'(m_req()));
    if (m_req()) chk("im_addr", im_addr, m_addr);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("inst", inst, m_valid ? m_inst : NOP_INST);
    if (m_valid) begin
      chk("pc_cur", pc_cur, m_pc);
      chk("pc_add4", pc_add4, m_pc + 32'd4);
    end
  endtask

  // Apply inputs for the coming edge and advance the model across it.
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
    logic req, ack;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    req         = m_req();
    ack         = req && (lat_cnt >= lat_target);
    im_ack      = ack;
    im_rdata    = mem_word(im_addr);
    if (rst) begin
      im_ack     = 1'b0;
      lat_cnt    = 0;
      lat_target = pick_lat();
      model_reset();
    end else begin
      if (ack) begin
        lat_cnt    = 0;
        lat_target = pick_lat();
      end else if (req) begin
        lat_cnt++;
      end
      if (rd) begin
        m_valid = 1'b0;
        m_buf_pc.delete();
        m_buf_inst.delete();
        if (req && !ack) begin
          m_drop    = 1'b1;
          m_next_pc = rpc;
        end else begin
          m_drop = 1'b0;
          m_addr = rpc;
        end
      end else if (m_buf_pc.size() != 0) begin
        if (!st) begin
          m_valid = 1'b1;
          m_pc    = m_buf_pc.pop_front();
          m_inst  = m_buf_inst.pop_front();
        end
      end else if (m_drop) begin
        if (ack) begin
          m_drop = 1'b0;
          m_addr = m_next_pc;
        end
      end else if (ack) begin
        if (!m_valid || !st) begin
          m_valid = 1'b1;
          m_pc    = m_addr;
          m_inst  = mem_word(m_addr);
        end else begin
          m_buf_pc.push_back(m_addr);
          m_buf_inst.push_back(mem_word(m_addr));
        end
        m_addr = m_addr + 32'd4;
      end else if (!st) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      sample();
      if (if_valid) begin
        ok = 1'b1;
        return;
      end
      drive(1'b0, 1'b0, 32'h0);
    end
    chk("wait_valid_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   rst_left;
    model_reset();
    #1 rst = 1'b1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_im_req", 32'(im_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_pc_cur", pc_cur, 32'h0);
      chk("rst_pc_add4", pc_add4, 32'h4);
      if (i == 1) rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
    end

    // Zero-wait streaming from RESET_PC
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("seq_pc", pc_cur, 32'(i * 4));
      chk("seq_valid", 32'(if_valid), 32'd1);
      if (i < 3) drive(1'b0, 1'b0, 32'h0);
    end

    // Stall 4 cycles while the 0x10 response lands in the skid
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("hold_req", 32'(im_req), 32'd0);
      chk("hold_pc", pc_cur, 32'h0000_000C);
      drive(i < 3, 1'b0, 32'h0);
    end
    sample();
    chk("unhold_pc", pc_cur, 32'h0000_0010);
    chk("unhold_addr", im_addr, 32'h0000_0014);
    drive(1'b0, 1'b0, 32'h0);
    sample();
    drive(1'b0, 1'b0, 32'h0);
    sample();
    lat_fixed = 2;
    drive(1'b0, 1'b0, 32'h0);

    // Redirect to 0x100 while 0x20 is outstanding
    sample();
    chk("pre_redir_pc", pc_cur, 32'h0000_001C);
    chk("pre_redir_addr", im_addr, 32'h0000_0020);
    drive(1'b0, 1'b1, 32'h0000_0100);
    lat_fixed = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("discard_addr", im_addr, 32'h0000_0020);
      chk("discard_valid", 32'(if_valid), 32'd0);
      drive(1'b0, 1'b0, 32'h0);
    end
    sample();
    chk("post_discard_addr", im_addr, 32'h0000_0100);
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("redir_pc", pc_cur, 32'h0000_0100);
    chk("redir_inst", inst, 32'h0000_0100 ^ 32'hC0DE_0003);

    // Redirect together with stall while the skid is full
    drive(1'b1, 1'b0, 32'h0);
    sample();
    chk("skid_full_req", 32'(im_req), 32'd0);
    drive(1'b1, 1'b1, 32'h0000_0200);
    sample();
    chk("rs_valid", 32'(if_valid), 32'd0);
    chk("rs_inst", inst, 32'h0000_0013);
    chk("rs_addr", im_addr, 32'h0000_0200);
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("rs_pc", pc_cur, 32'h0000_0200);
    chk("rs_pc_add4", pc_add4, 32'h0000_0204);

    // Three-cycle memory latency: three bubbles per instruction
    lat_fixed = 3;
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("lat_pc0", pc_cur, 32'h0000_0204);
    drive(1'b0, 1'b0, 32'h0);
    for (int j = 0; j < 3; j++) begin
      sample();
      chk("lat_bubble", 32'(if_valid), 32'd0);
      chk("lat_bubble_inst", inst, 32'h0000_0013);
      chk("lat_addr", im_addr, 32'h0000_0208);
      drive(1'b0, 1'b0, 32'h0);
    end
    sample();
    chk("lat_pc1", pc_cur, 32'h0000_0208);

    // PC wrap at 2^32
    lat_fixed = 0;
    drive(1'b0, 1'b1, 32'hFFFF_FFF8);
    wait_valid(12, ok);
    chk("wrap_pc0", pc_cur, 32'hFFFF_FFF8);
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("wrap_pc1", pc_cur, 32'hFFFF_FFFC);
    chk("wrap_add4", pc_add4, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("wrap_pc2", pc_cur, 32'h0);

    // Reset while a request is waiting
    lat_fixed = 3;
    drive(1'b0, 1'b0, 32'h0);
    sample();
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("midwait_req", 32'(im_req), 32'd1);
    lat_fixed = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    sample();
    chk("midrst_req", 32'(im_req), 32'd0);
    chk("midrst_valid", 32'(if_valid), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    wait_valid(4, ok);
    chk("restart_pc", pc_cur, TB_RESET_PC);

    // Randomized traffic
    lat_fixed = -1;
    rst_left = 0;
    drive(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 4000; c++) begin
      logic        st, rd;
      logic [31:0] rpc;
      sample();
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst      = 1'b1;
        rst_left = 2;
      end
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 8);
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      drive(st, rd, rpc);
    end
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the IF/ID segment register and supplies its `pc_cur`, `inst` and `pc_add4` inputs. It owns the fetch PC and runs a single-outstanding request/acknowledge handshake to instruction memory, so memory may have variable latency. A one-entry skid buffer absorbs a response that arrives while the decode stage is stalled. Taken branches and jumps redirect the PC; any in-flight stale fetch is discarded.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  IF/ID register holding this cycle; current output not consumed
- `redirect`  in  1  taken branch/jump from EX; overrides sequential fetch
- `redirect_pc`  in  32  target PC, valid when `redirect`=1
- `im_req`  out  1  instruction memory request
- `im_addr`  out  32  request address; stable while `im_req`=1 and not yet acked
- `im_ack`  in  1  response valid; may be asserted in the same cycle as `im_req` (zero-wait)
- `im_rdata`  in  32  instruction word, valid with `im_ack`
- `pc_cur`  out  32  PC of the instruction presented to IF/ID
- `inst`  out  32  instruction presented; NOP 32'h0000_0013 when `if_valid`=0
- `pc_add4`  out  32  `pc_cur`+4, modulo 2^32
- `if_valid`  out  1  presented instruction is real; 0 means the hazard unit inserts a bubble

## Operation
- Registers: `pc` (next fetch), `req_addr`, output slot (`pc_cur`, `inst`, `if_valid`), skid entry (pc, inst, valid), state.
- FETCH: `im_req`=1, `im_addr`=`req_addr`. A transfer completes in a cycle where `im_req`&&`im_ack`.
  - On completion with the output slot free (`if_valid`=0 or `stall`=0): load the slot; `pc`, `req_addr` <= `req_addr`+4; stay in FETCH.
  - On completion with the slot occupied and `stall`=1: write the skid entry; go to HOLD.
  - No completion and `stall`=0: `if_valid` <= 0 (bubble).
- HOLD: `im_req`=0. When `stall`=0, skid moves to the output slot, skid clears, return to FETCH.
- DISCARD: `im_req`=1 at the old `req_addr` until `im_ack`. The response is dropped. `req_addr` <= `pc`, then go to FETCH.
- Redirect has the highest priority over stall and completion in every state:
  - `pc`, `req_addr` <= `redirect_pc`; `if_valid` <= 0; skid clears.
  - If FETCH or DISCARD with `im_req`&&!`im_ack` this cycle, next state is DISCARD, keeping the old `im_addr` stable. Otherwise next state is FETCH at `redirect_pc`.
- `redirect_pc` low two bits are passed through unchecked; alignment faults are out of scope.
- PC arithmetic wraps at 2^32 (32'hFFFF_FFFC+4 = 0).

## Timing
- Reset values: `pc`=`req_addr`=`RESET_PC`, state FETCH, `if_valid`=0, `inst`=NOP, `pc_cur`=0, `pc_add4`=4, skid empty.
- `im_req`=0 while `rst`=1. Reset mid-transaction abandons it; memory must tolerate a dropped request.
- With zero-wait memory (`im_ack`=1), the first edge after reset release presents `RESET_PC`. Throughput is then one instruction per cycle.
- Latency is memory latency plus 1 edge, from `im_ack` to the outputs.
- Redirect asserted before edge N: with zero-wait memory, `redirect_pc` is presented after edge N+1. Nothing fetched before the redirect is ever presented after edge N.
- All outputs are registered except `im_req`/`im_addr`, which decode from state and `req_addr` only, with no combinational path from `im_ack`.

## Structure
- `riscv_pkg`: `NOP_INST` constant, fetch state enum (FETCH, HOLD, DISCARD), default `RESET_PC`.
- One sub-module: `fetch_skid_buf`, a one-entry pc+inst buffer with load/unload/clear and a valid flag.

## Test plan
- Reset release, `im_ack` tied 1, `RESET_PC`=0 -> `pc_cur` 0,4,8,12 on consecutive edges; `if_valid`=1 from the first edge.
- 3-cycle memory latency -> each instruction is followed by 3 bubbles (`if_valid`=0, `inst`=32'h13); `im_addr` is stable while waiting.
- `stall` high for 4 cycles while response for PC 0x10 arrives -> HOLD, `im_req`=0. After release, 0x0C then 0x10 are presented in order; no loss or duplicate.
- `redirect` to 0x100 while a request for 0x20 is outstanding (ack 2 cycles later) -> 0x20 data dropped. First valid output is 0x100.
- `redirect` and `stall` asserted together with the skid full -> skid cleared, `if_valid`=0, next valid output is `redirect_pc`.
- `rst` asserted mid-wait, then released -> `im_req` low during reset; fetch restarts at `RESET_PC`.
